// File: rtl/lvds_word_aligner.sv
// Per-lane word aligner for deserialized LVDS data: hunts for the bit offset
// that reproduces the training word, verifies it, locks, and re-aligns the stream.
module lvds_word_aligner #(
    parameter int              NCHAN         = 4,
    parameter int              DW            = 8,
    parameter logic [DW-1:0]   TRAIN_PATTERN = 8'hB4,
    parameter int              LOCK_COUNT    = 16,
    parameter int              ERR_LIMIT     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        train,
    input  logic                        realign,
    input  logic [NCHAN*DW-1:0]         din,
    input  logic                        din_valid,
    output logic [NCHAN*DW-1:0]         dout,
    output logic                        dout_valid,
    output logic [NCHAN*$clog2(DW)-1:0] slip_pos,
    output logic [NCHAN-1:0]            locked,
    output logic                        all_locked,
    output logic [NCHAN*2-1:0]          state_dbg
);

    localparam int              SW       = $clog2(DW);
    localparam logic [7:0]      LOCK_CNT = 8'(LOCK_COUNT);
    localparam logic [7:0]      ERR_LIM  = 8'(ERR_LIMIT);
    localparam logic [SW-1:0]   SLIP_MAX = SW'(DW - 1);

    // Encoding is visible on state_dbg (2 bits per lane, IDLE = 0).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    logic dout_valid_q;
    logic all_locked_q;

    for (genvar i = 0; i < NCHAN; i++) begin : g_lane
        state_t          state_q, state_d;
        logic [SW-1:0]   slip_q, slip_d, slip_inc;
        logic [7:0]      cnt_q, cnt_d, err_q, err_d;
        logic [DW-1:0]   prev_q, dout_q, din_l, w;
        logic [2*DW-1:0] cat;
        logic            match;

        assign din_l    = din[i*DW +: DW];
        assign cat      = {din_l, prev_q};
        assign w        = cat[slip_q +: DW];
        assign match    = (w == TRAIN_PATTERN);
        assign slip_inc = (slip_q == SLIP_MAX) ? '0 : slip_q + 1'b1;

        always_comb begin
            state_d = state_q;
            slip_d  = slip_q;
            cnt_d   = cnt_q;
            err_d   = err_q;
            if (realign) begin
                cnt_d   = '0;
                err_d   = '0;
                state_d = train ? ST_SEARCH : ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (train && din_valid) begin
                            state_d = ST_SEARCH;
                            cnt_d   = '0;
                        end
                    end
                    ST_SEARCH: begin
                        if (!train) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (din_valid) begin
                            if (match && LOCK_CNT == 8'd1) begin
                                state_d = ST_LOCKED;
                                cnt_d   = '0;
                                err_d   = '0;
                            end else if (match) begin
                                state_d = ST_VERIFY;
                                cnt_d   = 8'd1;
                            end else begin
                                slip_d  = slip_inc;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (!train) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (din_valid) begin
                            if (match && (cnt_q + 8'd1) == LOCK_CNT) begin
                                state_d = ST_LOCKED;
                                cnt_d   = '0;
                                err_d   = '0;
                            end else if (match) begin
                                cnt_d   = cnt_q + 8'd1;
                            end else begin
                                state_d = ST_SEARCH;
                                slip_d  = slip_inc;
                                cnt_d   = '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        // Offset is frozen; errors are only counted while training.
                        if (!train) begin
                            err_d = '0;
                        end else if (din_valid) begin
                            if (match) begin
                                err_d = '0;
                            end else if ((err_q + 8'd1) == ERR_LIM) begin
                                state_d = ST_SEARCH;
                                slip_d  = slip_inc;
                                err_d   = '0;
                            end else begin
                                err_d = err_q + 8'd1;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= ST_IDLE;
                slip_q  <= '0;
                cnt_q   <= '0;
                err_q   <= '0;
                prev_q  <= '0;
                dout_q  <= '0;
            end else begin
                state_q <= state_d;
                slip_q  <= slip_d;
                cnt_q   <= cnt_d;
                err_q   <= err_d;
                if (din_valid) begin
                    prev_q <= din_l;
                    dout_q <= w;
                end
            end
        end

        assign dout[i*DW +: DW]      = dout_q;
        assign slip_pos[i*SW +: SW]  = slip_q;
        assign locked[i]             = (state_q == ST_LOCKED);
        assign state_dbg[i*2 +: 2]   = state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_valid_q <= 1'b0;
            all_locked_q <= 1'b0;
        end else begin
            dout_valid_q <= din_valid;
            all_locked_q <= &locked;
        end
    end

    assign dout_valid = dout_valid_q;
    assign all_locked = all_locked_q;

endmodule

// File: doc/lvds_word_aligner.md
Name: lvds_word_aligner

Overview:
- Multi-channel word aligner for deserialized LVDS data.
- Sits on the divided-clock side of the per-lane 1:DW input deserializers. Takes raw parallel words whose word boundary is arbitrary.
- While the far end sends a fixed training word, each lane hunts for the bit offset that reproduces it, verifies it, then locks.
- Outputs boundary-corrected words plus per-lane and global lock status.

Parameters:
- NCHAN, 4, number of lanes.
- DW, 8, deserialized word width in bits (2..16).
- TRAIN_PATTERN, 8'hB4, DW-bit training word; all DW rotations must be distinct.
- LOCK_COUNT, 16, consecutive matches required in VERIFY before LOCKED (1..255).
- ERR_LIMIT, 4, consecutive mismatches in LOCKED, while train=1, that drop lock (1..255).

Ports:
- clk, in, 1, divided (word-rate) clock; all logic on rising edge.
- reset, in, 1, synchronous active-high reset.
- train, in, 1, level; high while the link transmits TRAIN_PATTERN on every lane.
- realign, in, 1, single-cycle pulse; forces every lane out of lock.
- din, in, NCHAN*DW, raw deserializer words; lane i = din[i*DW +: DW].
- din_valid, in, 1, qualifies din (common to all lanes).
- dout, out, NCHAN*DW, aligned words, same lane packing as din.
- dout_valid, out, 1, qualifies dout.
- slip_pos, out, NCHAN*$clog2(DW), current bit offset per lane.
- locked, out, NCHAN, per-lane lock.
- all_locked, out, 1, AND of locked, registered.

Behaviour:
- Reset:
  - dout=0, dout_valid=0, slip_pos=0, locked=0, all_locked=0.
  - Every lane's prev word=0, counters=0, state=IDLE.
  - reset has priority over realign, train and din_valid.
- Window select:
  - Per lane, cat = {din_lane, prev_lane} (2*DW bits, current word in MSBs).
  - Candidate word w = cat[slip_pos +: DW] (combinational mux).
  - prev_lane <= din_lane on each din_valid.
- Datapath:
  - On din_valid, dout lane <= w and dout_valid <= 1 on the next edge (latency 1). Otherwise dout_valid <= 0 and dout holds.
  - dout is produced in every state, locked or not.
- Per-lane FSM: all comparisons and counter updates happen only on din_valid cycles; states and counters hold otherwise.
  - IDLE: if train=1 -> SEARCH, with count=0.
  - SEARCH:
    - w==TRAIN_PATTERN -> VERIFY, count=1.
    - Else slip_pos <= slip_pos+1, wrapping DW-1 -> 0; stay in SEARCH. No hunt timeout; the offset wraps forever.
  - VERIFY:
    - Match -> count+1.
    - When count reaches LOCK_COUNT (including LOCK_COUNT=1, i.e. directly from SEARCH) -> LOCKED, locked=1, err=0.
    - Mismatch -> SEARCH, slip_pos+1, count=0.
  - LOCKED:
    - slip_pos frozen.
    - If train=1: match clears err; mismatch increments err. err reaching ERR_LIMIT -> SEARCH, locked=0, slip_pos+1, err=0.
    - If train=0: no checking; err cleared; stays LOCKED.
  - train=0 in SEARCH or VERIFY -> IDLE at the next edge, regardless of din_valid. Counters clear; slip_pos retained.
  - realign=1 (any state):
    - locked=0, counters clear, slip_pos retained.
    - Next state is SEARCH if train=1, else IDLE.
    - Takes priority over the same-cycle FSM update.
- locked changes on the same edge as the state change into or out of LOCKED.
- all_locked = registered AND of locked, one cycle behind.
- Lanes are fully independent except for shared train, realign and din_valid.

Test Plan:
- Reset check:
  - Stimulus: assert reset for 3 cycles while din_valid=1, train=1 and din is random.
  - Required: all outputs 0 during reset, including dout_valid; state IDLE on release.
- Offset hunt:
  - Stimulus: train=1, din_valid=1 every cycle. Lane i carries a continuous B4 stream such that the correct word sits at cat[(2*i+1) +: 8], giving offsets 1, 3, 5, 7.
  - Required: slip_pos settles to 1, 3, 5, 7. locked[i] rises no later than 2*DW+LOCK_COUNT valid cycles after train rises. all_locked follows one cycle after the last lane locks. dout = 8'hB4 on every lane from then on.
- din_valid gaps:
  - Stimulus: same as the offset hunt, but din_valid asserted only every 3rd cycle.
  - Required: identical final slip_pos values. Lock latency is counted in valid cycles only. dout_valid pulses exactly one cycle after each din_valid.
- Loss of lock:
  - Stimulus: lane 0 locked at offset 3. Inject 3 corrupted words, then B4 words, then 4 consecutive corrupted words, with train=1.
  - Required: no unlock after the first 3 errors (err clears on the next match). Unlock on the 4th consecutive error: locked[0]=0, slip_pos[0]=4, all_locked falls one cycle later.
- train low while locked:
  - Stimulus: lock all lanes, drop train, apply random data for 100 cycles.
  - Required: locked stays all ones and slip_pos is unchanged.
- realign and simultaneity:
  - Stimulus: lock all lanes, then pulse realign with train=1.
  - Required: locked=0 next edge and lanes re-lock at the same offsets.
  - Stimulus: realign in the same cycle as reset.
  - Required: reset values.
